// File: rtl/ascon_pkg.sv
// Shared definitions for the Ascon-Hash sponge controller.
// Holds the FSM state encoding, the rate width, the Ascon-Hash IV, the
// padding word used for an extra all-padding block, and the state that
// results from running p12 over the IV (used when the init permutation is
// skipped).
package ascon_pkg;

    localparam int RATE_W = 64;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        PWAIT,
        ABSORB,
        PAD,
        SQZ_OUT
    } state_e;

    localparam logic [RATE_W-1:0] IV_DEFAULT = 64'h00400c0000000100;
    localparam logic [RATE_W-1:0] PAD_WORD   = 64'h8000000000000000;

    // p12({IV,0,0,0,0})
    localparam logic [63:0] PRE_X0 = 64'hee9398aadb67f03d;
    localparam logic [63:0] PRE_X1 = 64'h8bb21831c60f1002;
    localparam logic [63:0] PRE_X2 = 64'hb48a92db98d5da62;
    localparam logic [63:0] PRE_X3 = 64'h43189921b8f8e3e8;
    localparam logic [63:0] PRE_X4 = 64'h348fa5c9d525e140;

endpackage

// File: rtl/ascon_hash_ctrl_pad64.sv
// Combinational absorb-word formatter.
// Turns a message word into the 64-bit block XORed into x0:
//   - not last: the word passes through unchanged
//   - last, n < 8 valid bytes: upper n bytes kept, byte n = 0x80, rest zero
//   - last, n = 8 (values above 8 clamp to 8): word passes through and
//     full_last flags that a separate padding block must follow
// Ports:
//   msg_data  [63:0] in   message word, byte 0 in bits [63:56]
//   msg_bytes [3:0]  in   valid bytes in a last word
//   msg_last         in   word is the final one
//   word      [63:0] out  block to absorb
//   full_last        out  last word was completely full
import ascon_pkg::*;

module ascon_pad64 (
    input  logic [RATE_W-1:0] msg_data,
    input  logic [3:0]        msg_bytes,
    input  logic              msg_last,
    output logic [RATE_W-1:0] word,
    output logic              full_last
);

    logic [3:0] n;

    always_comb begin
        n = (msg_bytes > 4'd8) ? 4'd8 : msg_bytes;
        word = '0;
        for (int i = 0; i < 8; i++) begin
            if (!msg_last || (4'(i) < n)) begin
                word[63-8*i -: 8] = msg_data[63-8*i -: 8];
            end else if (4'(i) == n) begin
                word[63-8*i -: 8] = 8'h80;
            end
        end
        full_last = msg_last && (n == 4'd8);
    end

endmodule

// File: rtl/ascon_hash_ctrl.sv
// Ascon-Hash sponge controller sitting in front of a registered p12 stage.
// Owns the 320-bit state x0..x4, runs the init permutation, absorbs 64-bit
// message blocks with padding and squeezes four 64-bit digest words.
// Optional build macro ASCON_HASH_PRECOMP_IV_EN: start loads the post-init
// state directly and skips the init permutation.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   start                      begin a hash (only honoured in IDLE)
//   msg_valid/msg_ready        message handshake
//   msg_data/msg_last/msg_bytes message word, last flag, bytes in last word
//   perm_en                    one-cycle strobe to the stage process_en
//   st_x0_o..st_x4_o           state presented to the stage
//   st_x0_i..st_x4_i           stage result
//   digest_valid/digest_ready  digest handshake
//   digest_data/idx/last       digest word, index 0..3, last flag
//   busy                       high outside IDLE
import ascon_pkg::*;

module ascon_hash_ctrl #(
    parameter int unsigned P_LAT = 1,
    parameter logic [63:0] IV    = IV_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        msg_valid,
    output logic        msg_ready,
    input  logic [63:0] msg_data,
    input  logic        msg_last,
    input  logic [3:0]  msg_bytes,
    output logic        perm_en,
    output logic [63:0] st_x0_o,
    output logic [63:0] st_x1_o,
    output logic [63:0] st_x2_o,
    output logic [63:0] st_x3_o,
    output logic [63:0] st_x4_o,
    input  logic [63:0] st_x0_i,
    input  logic [63:0] st_x1_i,
    input  logic [63:0] st_x2_i,
    input  logic [63:0] st_x3_i,
    input  logic [63:0] st_x4_i,
    output logic        digest_valid,
    input  logic        digest_ready,
    output logic [63:0] digest_data,
    output logic [1:0]  digest_idx,
    output logic        digest_last,
    output logic        busy
);

    localparam logic [3:0] LAT = 4'(P_LAT);

    state_e      state, state_nxt;
    state_e      ret, ret_nxt;
    logic [63:0] x0, x1, x2, x3, x4;
    logic [63:0] x0_nxt, x1_nxt, x2_nxt, x3_nxt, x4_nxt;
    logic [3:0]  pcnt, pcnt_nxt;
    logic [1:0]  sq_cnt, sq_nxt;
    logic        perm_req, perm_req_nxt;
    logic [63:0] abs_word;
    logic        abs_full;

    ascon_pad64 u_pad (
        .msg_data  (msg_data),
        .msg_bytes (msg_bytes),
        .msg_last  (msg_last),
        .word      (abs_word),
        .full_last (abs_full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ret      <= IDLE;
            x0       <= '0;
            x1       <= '0;
            x2       <= '0;
            x3       <= '0;
            x4       <= '0;
            pcnt     <= '0;
            sq_cnt   <= '0;
            perm_req <= 1'b0;
        end else begin
            state    <= state_nxt;
            ret      <= ret_nxt;
            x0       <= x0_nxt;
            x1       <= x1_nxt;
            x2       <= x2_nxt;
            x3       <= x3_nxt;
            x4       <= x4_nxt;
            pcnt     <= pcnt_nxt;
            sq_cnt   <= sq_nxt;
            perm_req <= perm_req_nxt;
        end
    end

    // pcnt holds the number of cycles elapsed since perm_en was high.
    // INIT and PAD strobe perm_en themselves, so PWAIT starts at 1 after them;
    // after a message or digest handshake the strobe comes from perm_req in
    // the first PWAIT cycle, so PWAIT starts at 0.
    always_comb begin
        state_nxt    = state;
        ret_nxt      = ret;
        x0_nxt       = x0;
        x1_nxt       = x1;
        x2_nxt       = x2;
        x3_nxt       = x3;
        x4_nxt       = x4;
        pcnt_nxt     = pcnt;
        sq_nxt       = sq_cnt;
        perm_req_nxt = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    sq_nxt   = '0;
                    pcnt_nxt = '0;
`ifdef ASCON_HASH_PRECOMP_IV_EN
                    x0_nxt    = PRE_X0;
                    x1_nxt    = PRE_X1;
                    x2_nxt    = PRE_X2;
                    x3_nxt    = PRE_X3;
                    x4_nxt    = PRE_X4;
                    state_nxt = ABSORB;
`else
                    x0_nxt    = IV;
                    x1_nxt    = '0;
                    x2_nxt    = '0;
                    x3_nxt    = '0;
                    x4_nxt    = '0;
                    state_nxt = INIT;
`endif
                end
            end

            INIT: begin
                ret_nxt   = ABSORB;
                pcnt_nxt  = 4'd1;
                state_nxt = PWAIT;
            end

            PWAIT: begin
                if (pcnt == LAT) begin
                    x0_nxt    = st_x0_i;
                    x1_nxt    = st_x1_i;
                    x2_nxt    = st_x2_i;
                    x3_nxt    = st_x3_i;
                    x4_nxt    = st_x4_i;
                    // The padding block is folded in on the way into PAD so
                    // the state seen by the stage during the PAD strobe is
                    // already padded.
                    if (ret == PAD) begin
                        x0_nxt = st_x0_i ^ PAD_WORD;
                    end
                    state_nxt = ret;
                end else begin
                    pcnt_nxt = pcnt + 4'd1;
                end
            end

            ABSORB: begin
                if (msg_valid) begin
                    x0_nxt       = x0 ^ abs_word;
                    pcnt_nxt     = '0;
                    perm_req_nxt = 1'b1;
                    state_nxt    = PWAIT;
                    if (!msg_last) begin
                        ret_nxt = ABSORB;
                    end else if (abs_full) begin
                        ret_nxt = PAD;
                    end else begin
                        ret_nxt = SQZ_OUT;
                        sq_nxt  = '0;
                    end
                end
            end

            PAD: begin
                ret_nxt   = SQZ_OUT;
                sq_nxt    = '0;
                pcnt_nxt  = 4'd1;
                state_nxt = PWAIT;
            end

            SQZ_OUT: begin
                if (digest_ready) begin
                    if (sq_cnt == 2'd3) begin
                        state_nxt = IDLE;
                    end else begin
                        sq_nxt       = sq_cnt + 2'd1;
                        pcnt_nxt     = '0;
                        perm_req_nxt = 1'b1;
                        ret_nxt      = SQZ_OUT;
                        state_nxt    = PWAIT;
                    end
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

    assign perm_en      = (state == INIT) || (state == PAD) || perm_req;
    assign msg_ready    = (state == ABSORB);
    assign digest_valid = (state == SQZ_OUT);
    assign digest_data  = digest_valid ? x0 : '0;
    assign digest_idx   = digest_valid ? sq_cnt : 2'd0;
    assign digest_last  = digest_valid && (sq_cnt == 2'd3);
    assign busy         = (state != IDLE);

    assign st_x0_o = x0;
    assign st_x1_o = x1;
    assign st_x2_o = x2;
    assign st_x3_o = x3;
    assign st_x4_o = x4;

endmodule
